compare_5b: RTL and testbench
=============================

# compare_5b

Registered magnitude comparator for two unsigned operands, 5 bits wide by default. It produces three mutually exclusive flags: equal, A greater, B greater. It is a leaf datapath block used wherever a clocked ordering decision between two buses is needed. The outputs are registered so downstream logic sees a clean, glitch-free one-hot result.

## Interface
Parameters:
- WIDTH, 5: operand width in bits; legal range 1–32.
- SIGNED, 0: 0 compares unsigned; 1 compares two's-complement signed.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- S  output  1  registered flag: A equals B.
- Ab  output  1  registered flag: A greater than B.
- Bb  output  1  registered flag: B greater than A.

## Operation
- Combinational compare each cycle:
  - eq = (A == B)
  - a_gt = A > B
  - b_gt = B > A
- Interpretation of A and B follows SIGNED.
- Equality is bitwise and independent of SIGNED.
- The magnitude decision is made MSB-first. The first differing bit decides the result.
- When SIGNED=1, the MSB sense is inverted: the operand with MSB=0 is larger.
- On each rising clk edge with rst_n=1, the flags are registered: S<=eq, Ab<=a_gt, Bb<=b_gt.
- Invariant out of reset: exactly one of S, Ab, Bb is 1 (one-hot) in every cycle after the first post-reset clock edge.
- Reset state: S=0, Ab=0, Bb=0. All-zero is the only legal non-one-hot state and means "no valid result yet".
- No enable and no hold: the outputs track the inputs every cycle.
- X/Z on the inputs is not handled; results are undefined in that case.

## Timing
- Latency: 1 clk cycle from input change to flag update.
  - Inputs sampled at edge N appear on S/Ab/Bb immediately after edge N.
  - They remain stable until edge N+1.
- Reset assertion (rst_n falling):
  - S, Ab, Bb go to 0 immediately, without waiting for clk.
  - This also applies when reset is asserted mid-operation.
- Reset deassertion:
  - Release is synchronised into the flag registers.
  - The first valid result appears at the first rising edge with rst_n=1.
- Inputs must meet setup/hold to clk. Inputs that change between edges have no effect until the next edge.
- Boundary values must resolve in one cycle with no special casing:
  - all-zeros vs all-zeros gives S=1.
  - all-ones vs all-ones gives S=1.
  - max vs 0 gives Ab=1 (unsigned) or Bb=1 (signed).

## Test plan
Default parameters (WIDTH=5, SIGNED=0) unless stated:
- Reset: hold rst_n=0 with any A/B -> S=Ab=Bb=0 asynchronously. Release with A=5'b00000, B=5'b00000 -> after the next edge, S=1, Ab=0, Bb=0.
- A=5'b01100 (12), B=5'b00110 (6) -> after one edge, Ab=1, S=0, Bb=0.
- A=5'b01100 (12), B=5'b01110 (14) -> after one edge, Bb=1, S=0, Ab=0.
  - The operands first differ at bit 1, so this checks a low-order tiebreak.
- A=5'b11110 (30), B=5'b11110 (30) -> after one edge, S=1, Ab=0, Bb=0.
- Boundary and invariant sweep:
  - A=5'b11111, B=5'b00000 -> Ab=1.
  - Swap the operands -> Bb=1.
  - Exhaustive 32×32 sweep -> each result matches the reference relation and is one-hot after one edge.
  - Assert rst_n=0 mid-sweep between edges -> all flags 0 immediately.
- SIGNED=1:
  - A=5'b11110 (-2), B=5'b00001 (+1) -> Bb=1.
  - A=5'b10000 (-16), B=5'b01111 (+15) -> Bb=1.
  - A=B=5'b10000 -> S=1.

Source files
------------

// File: rtl/compare_5b.sv
// Registered magnitude comparator: one-hot equal / A-greater / B-greater flags,
// unsigned or two's-complement, one clock of latency.
module compare_5b #(
  parameter int WIDTH  = 5,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             S,
  output logic             Ab,
  output logic             Bb
);

  logic w_eq;
  logic w_a_gt;
  logic w_b_gt;
  logic w_decided;

  // MSB-first scan: the first differing bit decides. In signed mode the sign
  // bit has inverted weight, so a 0 there marks the larger operand.
  always_comb begin
    w_eq      = (A == B);
    w_a_gt    = 1'b0;
    w_b_gt    = 1'b0;
    w_decided = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_decided && (A[i] != B[i])) begin
        w_decided = 1'b1;
        if ((SIGNED != 0) && (i == WIDTH - 1)) begin
          w_a_gt = B[i];
          w_b_gt = A[i];
        end else begin
          w_a_gt = A[i];
          w_b_gt = B[i];
        end
      end
    end
  end

  // All-zero after reset means "no valid result yet"; one-hot from the first
  // edge with rst_n released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S  <= 1'b0;
      Ab <= 1'b0;
      Bb <= 1'b0;
    end else begin
      S  <= w_eq;
      Ab <= w_a_gt;
      Bb <= w_b_gt;
    end
  end

endmodule

// File: tb/tb_compare_5b.sv
// Directed bench for compare_5b: unsigned default instance plus a SIGNED=1
// instance, both driven on the falling edge and sampled 1 ns after the rising edge.
module tb_compare_5b;

  logic       clk;
  logic       rst_n;
  logic [4:0] ua, ub, sa, sb;
  logic       u_s, u_ab, u_bb;
  logic       s_s, s_ab, s_bb;

  int errors = 0;
  int checks = 0;

  compare_5b #(.WIDTH(5), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .A(ua), .B(ub), .S(u_s), .Ab(u_ab), .Bb(u_bb)
  );

  compare_5b #(.WIDTH(5), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .A(sa), .B(sb), .S(s_s), .Ab(s_ab), .Bb(s_bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_u(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    ua = a;
    ub = b;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    sa = a;
    sb = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    rst_n = 1'b0;
    ua = 5'b10101; ub = 5'b01010;
    sa = 5'b00011; sb = 5'b11100;
    repeat (3) @(posedge clk);
    #1;
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold_u: got S/Ab/Bb=%b expected 000", got);
    end
    got = {s_s, s_ab, s_bb};
    checks++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold_s: got S/Ab/Bb=%b expected 000", got);
    end
    @(negedge clk);
    ua = 5'b00000; ub = 5'b00000;
    rst_n = 1'b1;
    #1;
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL release_before_edge: got S/Ab/Bb=%b expected 000", got);
    end
    @(posedge clk);
    #1;
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b100) begin
      errors++;
      $display("FAIL release_first_edge: got S/Ab/Bb=%b expected 100", got);
    end
  endtask

  task automatic test_basic();
    logic [2:0] got;
    drive_u(5'b01100, 5'b00110);
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b010) begin
      errors++;
      $display("FAIL u_12_vs_6: got S/Ab/Bb=%b expected 010", got);
    end
    drive_u(5'b01100, 5'b01110);
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL u_12_vs_14: got S/Ab/Bb=%b expected 001", got);
    end
    drive_u(5'b11110, 5'b11110);
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b100) begin
      errors++;
      $display("FAIL u_30_vs_30: got S/Ab/Bb=%b expected 100", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got;
    drive_u(5'b00011, 5'b00010);
    // input change between edges must not show until the next edge
    ua = 5'b00001;
    #2;
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b010) begin
      errors++;
      $display("FAIL hold_between_edges: got S/Ab/Bb=%b expected 010", got);
    end
    @(posedge clk);
    #1;
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL next_edge_update: got S/Ab/Bb=%b expected 001", got);
    end
  endtask

  task automatic test_boundary();
    logic [2:0] got;
    drive_u(5'b11111, 5'b00000);
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b010) begin
      errors++;
      $display("FAIL u_max_vs_0: got S/Ab/Bb=%b expected 010", got);
    end
    drive_u(5'b00000, 5'b11111);
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL u_0_vs_max: got S/Ab/Bb=%b expected 001", got);
    end
    drive_u(5'b11111, 5'b11111);
    got = {u_s, u_ab, u_bb};
    checks++;
    if (got !== 3'b100) begin
      errors++;
      $display("FAIL u_ones_vs_ones: got S/Ab/Bb=%b expected 100", got);
    end
  endtask

  task automatic test_signed();
    logic [2:0] got;
    drive_s(5'b11110, 5'b00001);
    got = {s_s, s_ab, s_bb};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL s_m2_vs_p1: got S/Ab/Bb=%b expected 001", got);
    end
    drive_s(5'b10000, 5'b01111);
    got = {s_s, s_ab, s_bb};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL s_m16_vs_p15: got S/Ab/Bb=%b expected 001", got);
    end
    drive_s(5'b10000, 5'b10000);
    got = {s_s, s_ab, s_bb};
    checks++;
    if (got !== 3'b100) begin
      errors++;
      $display("FAIL s_m16_eq: got S/Ab/Bb=%b expected 100", got);
    end
    drive_s(5'b11111, 5'b00000);
    got = {s_s, s_ab, s_bb};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL s_ones_vs_0: got S/Ab/Bb=%b expected 001", got);
    end
    drive_s(5'b00010, 5'b00011);
    got = {s_s, s_ab, s_bb};
    checks++;
    if (got !== 3'b001) begin
      errors++;
      $display("FAIL s_p2_vs_p3: got S/Ab/Bb=%b expected 001", got);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] got_u, got_s, exp_u, exp_s;
    int         sva, svb;
    int         bad_u, bad_s;
    bad_u = 0;
    bad_s = 0;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        ua = 5'(a); ub = 5'(b);
        sa = 5'(a); sb = 5'(b);
        @(posedge clk);
        #1;
        sva   = (a >= 16) ? a - 32 : a;
        svb   = (b >= 16) ? b - 32 : b;
        exp_u = (a == b) ? 3'b100 : ((a > b) ? 3'b010 : 3'b001);
        exp_s = (sva == svb) ? 3'b100 : ((sva > svb) ? 3'b010 : 3'b001);
        got_u = {u_s, u_ab, u_bb};
        got_s = {s_s, s_ab, s_bb};
        checks++;
        if (got_u !== exp_u) begin
          errors++;
          if (bad_u < 8)
            $display("FAIL sweep_u a=%0d b=%0d: got S/Ab/Bb=%b expected %b", a, b, got_u, exp_u);
          bad_u++;
        end
        checks++;
        if (got_s !== exp_s) begin
          errors++;
          if (bad_s < 8)
            $display("FAIL sweep_s a=%0d b=%0d: got S/Ab/Bb=%b expected %b", sva, svb, got_s, exp_s);
          bad_s++;
        end
      end
      if (a == 17) begin
        // asynchronous reset asserted between edges, mid-sweep
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        got_u = {u_s, u_ab, u_bb};
        got_s = {s_s, s_ab, s_bb};
        checks++;
        if ({got_u, got_s} !== 6'b000000) begin
          errors++;
          $display("FAIL midsweep_reset: got u=%b s=%b expected 000/000", got_u, got_s);
        end
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_boundary();
    test_signed();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
